rps_round_referee: RTL

Round controller and score keeper for the rock-paper-scissors game, sitting directly downstream of the player-input capture and the move predictor. It accepts a validated player move and requests the AI's choice through a req/ack handshake. It then scores the round and publishes the 4-bit `{player, ai}` combination that the predictor consumes for its next update. Results are held for a display window, and the block stops in a game-over state when either side reaches the win target.

---
 rtl/rps_round_referee.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rps_round_referee.sv
// Rock-paper-scissors round referee: takes a player move, fetches the AI move
// over a req/ack handshake, scores the round, holds a display window and stops at game over.
module rps_round_referee #(
  parameter int WIN_TARGET  = 10,
  parameter int SHOW_CYCLES = 4,
  parameter int SCORE_W     = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [1:0]         player_move,
  output logic               ai_req,
  input  logic               ai_ack,
  input  logic [1:0]         ai_choice,
  output logic [3:0]         combination,
  output logic               combination_valid,
  output logic [1:0]         outcome,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] ai_score,
  output logic [SCORE_W-1:0] tie_count,
  output logic               busy,
  output logic               game_over,
  output logic [2:0]         state_dbg
);

  // Handshake: ai_req is a level held for the whole WAIT_AI state; ai_ack is a
  // one-cycle pulse that is only sampled while ai_req is high.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_AI = 3'd1,
    S_SCORE   = 3'd2,
    S_SHOW    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] SAT   = '1;

  state_t             state_q, state_d;
  logic [1:0]         player_q, player_d;
  logic [1:0]         ai_q, ai_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         comb_q, comb_d;
  logic               cv_q, cv_d;
  logic [1:0]         outcome_q, outcome_d;
  logic [SCORE_W-1:0] ps_q, ps_d;
  logic [SCORE_W-1:0] as_q, as_d;
  logic [SCORE_W-1:0] tc_q, tc_d;

  // (player - ai) mod 3 with both operands restricted to 0..2.
  logic [2:0] diff_w;
  logic [1:0] result_w;
  assign diff_w   = {1'b0, player_q} + 3'd3 - {1'b0, ai_q};
  assign result_w = (diff_w >= 3'd3) ? 2'(diff_w - 3'd3) : diff_w[1:0];

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    ai_d      = ai_q;
    cnt_d     = cnt_q;
    comb_d    = comb_q;
    cv_d      = 1'b0;
    outcome_d = outcome_q;
    ps_d      = ps_q;
    as_d      = as_q;
    tc_d      = tc_q;

    case (state_q)
      S_IDLE: begin
        if (move_valid && (player_move != 2'd3)) begin
          player_d = player_move;
          state_d  = S_WAIT_AI;
        end
      end
      S_WAIT_AI: begin
        if (ai_ack) begin
          ai_d    = (ai_choice == 2'd3) ? 2'd0 : ai_choice;
          state_d = S_SCORE;
        end
      end
      S_SCORE: begin
        outcome_d = result_w;
        comb_d    = {player_q, ai_q};
        cv_d      = 1'b1;
        case (result_w)
          2'd0:    if (tc_q != SAT) tc_d = tc_q + SCORE_W'(1);
          2'd1:    if (ps_q != SAT) ps_d = ps_q + SCORE_W'(1);
          default: if (as_q != SAT) as_d = as_q + SCORE_W'(1);
        endcase
        cnt_d   = CNT_W'(SHOW_CYCLES - 1);
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == '0) begin
          state_d = ((ps_q >= WIN_T) || (as_q >= WIN_T)) ? S_OVER : S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_OVER: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Soft clear overrides any same-cycle move or ack; the last combination is kept on display.
    if (new_game) begin
      state_d   = S_IDLE;
      ps_d      = '0;
      as_d      = '0;
      tc_d      = '0;
      outcome_d = 2'd0;
      comb_d    = comb_q;
      cv_d      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      player_q  <= 2'd0;
      ai_q      <= 2'd0;
      cnt_q     <= '0;
      comb_q    <= 4'd0;
      cv_q      <= 1'b0;
      outcome_q <= 2'd0;
      ps_q      <= '0;
      as_q      <= '0;
      tc_q      <= '0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      ai_q      <= ai_d;
      cnt_q     <= cnt_d;
      comb_q    <= comb_d;
      cv_q      <= cv_d;
      outcome_q <= outcome_d;
      ps_q      <= ps_d;
      as_q      <= as_d;
      tc_q      <= tc_d;
    end
  end

  assign ai_req            = (state_q == S_WAIT_AI);
  assign busy              = (state_q != S_IDLE);
  assign game_over         = (state_q == S_OVER);
  assign combination       = comb_q;
  assign combination_valid = cv_q;
  assign outcome           = outcome_q;
  assign player_score      = ps_q;
  assign ai_score          = as_q;
  assign tie_count         = tc_q;
  assign state_dbg         = state_q;

endmodule
